multicycle_controller: RTL and testbench

- Multicycle successor to the single-cycle main decoder.
- An FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the same datapath control set plus PC/IR write enables and jump control.
- Memory accesses use a ready handshake with a bounded-wait timeout. Illegal opcodes and memory timeouts enter a sticky TRAP state.
- Sits between the instruction register and the shared datapath. It replaces the combinational decoder when memories have variable latency.

---
 rtl/riscv_ctrl_pkg.sv | 67 ++++++
 rtl/mem_wait_timer.sv | 41 ++++
 rtl/multicycle_controller.sv | 221 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared opcode, state and control-field encodings for the multicycle controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_ctrl_pkg;

  // RV32I major opcodes recognised by the controller
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  // ALU operation class handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Register-file write-back source select
  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  // Reason the controller stopped
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Full datapath control word, one field per output port
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       alu_src;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       branch;
    logic       jump;
    logic       trap;
    logic [1:0] trap_cause;
  } ctl_t;

  // True for every opcode the controller knows how to sequence
  function automatic logic is_legal_op(input logic [6:0] op);
    logic legal;
    case (op)
      OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, OP_LUI: legal = 1'b1;
      default:                                                   legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on memory; flags the last allowed wait cycle.
// Latency: count updates one cycle after en_i; timeout_o is combinational from the count.
// Backpressure: none; the FSM clears it whenever it is not waiting.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins; the count saturates at the last wait cycle
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = (cnt_q == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with sticky TRAP; optional RETIRE_CNT_EN retire counter.
// Latency: BR 3 cycles, R/I/LUI/SW/JAL/JALR 4, LW 5 with zero-wait memory; each memory wait adds one.
// Backpressure: stalls in FETCH/MEM until mem_ready, traps after MEM_TIMEOUT wait cycles.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
`ifdef RETIRE_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       ALUSrc,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [1:0] ALUOp,
  output logic       Branch,
  output logic       Jump,
  output logic       Trap,
  output logic [1:0] TrapCause
`ifdef RETIRE_CNT_EN
  , output logic [CNT_W-1:0] retire_count
`endif
);

  state_t     state_q, state_d;
  logic [6:0] op_q, op_d;
  logic [1:0] cause_q, cause_d;
  ctl_t       ctl;

  logic tmr_clr;
  logic tmr_en;
  logic tmr_timeout;

  // Wait counter shared by instruction fetch and data access
  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait (
    .clk      (clk),
    .rst_n    (reset),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .timeout_o(tmr_timeout)
  );

  // Next-state and control-word decode from (state, latched opcode)
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cause_d = cause_q;
    tmr_clr = 1'b1;
    tmr_en  = 1'b0;
    ctl     = '0;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        ctl.mem_read = 1'b1;
        if (mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          state_d      = DECODE;
        end else if (tmr_timeout) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = TRAP;
        end else begin
          tmr_clr = 1'b0;
          tmr_en  = 1'b1;
        end
      end

      DECODE: begin
        // Only cycle in which the raw opcode is looked at
        op_d = Opcode;
        if (is_legal_op(Opcode)) begin
          state_d = EXEC;
        end else begin
          cause_d = CAUSE_ILLEGAL;
          state_d = TRAP;
        end
      end

      EXEC: begin
        case (op_q)
          OP_R: begin
            ctl.alu_op = ALUOP_FUNCT;
            state_d    = WB;
          end
          OP_I: begin
            ctl.alu_op  = ALUOP_FUNCT;
            ctl.alu_src = 1'b1;
            state_d     = WB;
          end
          OP_LW, OP_SW: begin
            ctl.alu_op  = ALUOP_ADD;
            ctl.alu_src = 1'b1;
            state_d     = MEM;
          end
          OP_LUI: begin
            ctl.alu_op  = ALUOP_ADD;
            ctl.alu_src = 1'b1;
            state_d     = WB;
          end
          OP_BR: begin
            // PC load is qualified by the ALU zero flag in the datapath
            ctl.alu_op = ALUOP_BR;
            ctl.branch = 1'b1;
            state_d    = FETCH;
          end
          OP_JAL, OP_JALR: begin
            ctl.alu_op  = ALUOP_ADD;
            ctl.alu_src = 1'b1;
            ctl.jump    = 1'b1;
            state_d     = WB;
          end
          default: begin
            // op_q is only ever loaded with a legal opcode; treat corruption as illegal
            cause_d = CAUSE_ILLEGAL;
            state_d = TRAP;
          end
        endcase
      end

      MEM: begin
        if (op_q == OP_SW) begin
          ctl.mem_write = 1'b1;
        end else begin
          ctl.mem_read = 1'b1;
        end
        if (mem_ready) begin
          state_d = (op_q == OP_SW) ? FETCH : WB;
        end else if (tmr_timeout) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = TRAP;
        end else begin
          tmr_clr = 1'b0;
          tmr_en  = 1'b1;
        end
      end

      WB: begin
        ctl.reg_write = 1'b1;
        if (op_q == OP_LW) begin
          ctl.mem_to_reg = M2R_MEM;
        end else if ((op_q == OP_JAL) || (op_q == OP_JALR)) begin
          ctl.mem_to_reg = M2R_PC4;
        end else begin
          ctl.mem_to_reg = M2R_ALU;
        end
        state_d = FETCH;
      end

      TRAP: begin
        ctl.trap       = 1'b1;
        ctl.trap_cause = cause_q;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched opcode and fault cause; reset aborts any instruction at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cause_q <= cause_d;
    end
  end

  assign PCWrite   = ctl.pc_write;
  assign IRWrite   = ctl.ir_write;
  assign ALUSrc    = ctl.alu_src;
  assign MemtoReg  = ctl.mem_to_reg;
  assign RegWrite  = ctl.reg_write;
  assign MemRead   = ctl.mem_read;
  assign MemWrite  = ctl.mem_write;
  assign ALUOp     = ctl.alu_op;
  assign Branch    = ctl.branch;
  assign Jump      = ctl.jump;
  assign Trap      = ctl.trap;
  assign TrapCause = ctl.trap_cause;

`ifdef RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_q;
  logic             retire_evt;

  // Last cycle of each instruction: branch resolve, store acknowledge, write-back
  assign retire_evt = ((state_q == EXEC) && (op_q == OP_BR)) ||
                      ((state_q == MEM) && (op_q == OP_SW) && mem_ready) ||
                      (state_q == WB);

  // Retired-instruction counter, wraps naturally, never moves in TRAP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_q <= '0;
    end else if (retire_evt) begin
      retire_q <= retire_q + CNT_W'(1);
    end
  end

  assign retire_count = retire_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: builds an expected per-cycle control trace per instruction, replays it.
// Latency: n/a.
// Backpressure: mem_ready stalls are injected from the instruction plan.
module tb_multicycle_controller;

  localparam int MT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] Opcode;
  logic       mem_ready;
  logic       PCWrite, IRWrite, ALUSrc, RegWrite, MemRead, MemWrite, Branch, Jump, Trap;
  logic [1:0] MemtoReg, ALUOp, TrapCause;
`ifdef RETIRE_CNT_EN
  logic [31:0] retire_count;
  logic [31:0] model_ret = 32'd0;
`endif

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .ALUOp(ALUOp),
    .Branch(Branch), .Jump(Jump), .Trap(Trap), .TrapCause(TrapCause)
`ifdef RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );

  // One planned cycle: inputs to drive and the control word that must appear
  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic [6:0]  opc;
    logic [14:0] want;
    logic        ret;
  } step_t;

  step_t      plan[$];
  step_t      cur;
  logic       cur_vld = 1'b0;
  int         tests = 0;
  int         fails = 0;
  int         stepno = 0;
  logic [6:0] legal_ops [0:7];

  wire [14:0] dut_vec = {PCWrite, IRWrite, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
                         ALUOp, Branch, Jump, Trap, TrapCause};

  function automatic logic [14:0] mk(bit pcw, bit irw, bit asrc, logic [1:0] m2r, bit rw,
                                     bit mr, bit mw, logic [1:0] aop, bit br, bit j,
                                     bit tr, logic [1:0] tc);
    return {pcw, irw, asrc, m2r, rw, mr, mw, aop, br, j, tr, tc};
  endfunction

  function automatic bit is_legal(logic [6:0] op);
    bit hit = 0;
    for (int k = 0; k < 8; k++) if (legal_ops[k] == op) hit = 1;
    return hit;
  endfunction

  task automatic push(bit rst, bit rdy, logic [6:0] opc, logic [14:0] want, bit ret);
    step_t s;
    s.rst = rst; s.rdy = rdy; s.opc = opc; s.want = want; s.ret = ret;
    plan.push_back(s);
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] ro();
    return 7'($urandom);
  endfunction

  // Sticky fault for n cycles, then an asynchronous reset and one idle cycle
  task automatic add_trap_and_reset(logic [1:0] cause, int n);
    for (int k = 0; k < n; k++) push(1, rb(), ro(), mk(0,0,0,2'b00,0,0,0,2'b00,0,0,1,cause), 0);
    push(0, rb(), ro(), 15'd0, 0);
    push(1, rb(), ro(), 15'd0, 0);
  endtask

  // Expected trace of one instruction with wf fetch waits and wm data waits
  task automatic add_instr(logic [6:0] op, int wf, int wm, output bit trapped);
    logic [14:0] ex, mv;
    bit is_st;
    trapped = 0;
    if (wf >= MT) begin
      for (int k = 0; k < MT; k++) push(1, 0, ro(), mk(0,0,0,2'b00,0,1,0,2'b00,0,0,0,2'b00), 0);
      trapped = 1;
      add_trap_and_reset(2'b10, 20);
      return;
    end
    for (int k = 0; k < wf; k++) push(1, 0, ro(), mk(0,0,0,2'b00,0,1,0,2'b00,0,0,0,2'b00), 0);
    push(1, 1, ro(), mk(1,1,0,2'b00,0,1,0,2'b00,0,0,0,2'b00), 0);
    push(1, rb(), op, 15'd0, 0);
    if (!is_legal(op)) begin
      trapped = 1;
      add_trap_and_reset(2'b01, 20);
      return;
    end
    case (op)
      7'b0110011: ex = mk(0,0,0,2'b00,0,0,0,2'b10,0,0,0,2'b00);
      7'b0010011: ex = mk(0,0,1,2'b00,0,0,0,2'b10,0,0,0,2'b00);
      7'b1100011: ex = mk(0,0,0,2'b00,0,0,0,2'b01,1,0,0,2'b00);
      7'b1101111,
      7'b1100111: ex = mk(0,0,1,2'b00,0,0,0,2'b00,0,1,0,2'b00);
      default:    ex = mk(0,0,1,2'b00,0,0,0,2'b00,0,0,0,2'b00);
    endcase
    push(1, rb(), ro(), ex, op == 7'b1100011);
    if (op == 7'b1100011) return;
    if (op == 7'b0000011 || op == 7'b0100011) begin
      is_st = (op == 7'b0100011);
      mv = mk(0,0,0,2'b00,0,!is_st,is_st,2'b00,0,0,0,2'b00);
      if (wm >= MT) begin
        for (int k = 0; k < MT; k++) push(1, 0, ro(), mv, 0);
        trapped = 1;
        add_trap_and_reset(2'b10, 20);
        return;
      end
      for (int k = 0; k < wm; k++) push(1, 0, ro(), mv, 0);
      push(1, 1, ro(), mv, is_st);
      if (is_st) return;
    end
    if (op == 7'b0000011)                         ex = mk(0,0,0,2'b01,1,0,0,2'b00,0,0,0,2'b00);
    else if (op == 7'b1101111 || op == 7'b1100111) ex = mk(0,0,0,2'b10,1,0,0,2'b00,0,0,0,2'b00);
    else                                          ex = mk(0,0,0,2'b00,1,0,0,2'b00,0,0,0,2'b00);
    push(1, rb(), ro(), ex, 1);
  endtask

  task automatic check_lit(string name, int got, int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic play();
    step_t s;
    while (plan.size() > 0) begin
      @(posedge clk);
      #1;
      s = plan.pop_front();
      reset = s.rst; mem_ready = s.rdy; Opcode = s.opc;
      cur = s; cur_vld = 1'b1;
    end
    @(negedge clk);
    #1;
    cur_vld = 1'b0;
  endtask

  // Single compare point, mid-cycle, against the planned control word
  always @(negedge clk) begin
    if (cur_vld) begin
      stepno++;
`ifdef RETIRE_CNT_EN
      if (!cur.rst) model_ret = 32'd0;
`endif
      tests++;
      if (dut_vec !== cur.want) begin
        fails++;
        $display("FAIL ctl step %0d: got %b, expected %b", stepno, dut_vec, cur.want);
      end
`ifdef RETIRE_CNT_EN
      tests++;
      if (retire_count !== model_ret) begin
        fails++;
        $display("FAIL retire step %0d: got %0d, expected %0d", stepno, retire_count, model_ret);
      end
      if (cur.ret) model_ret = model_ret + 32'd1;
`endif
    end
  end

  initial begin
    bit t;
    int n0, r, wf, wm;
    logic [6:0] op;
    legal_ops[0] = 7'b0110011; legal_ops[1] = 7'b0010011; legal_ops[2] = 7'b0000011;
    legal_ops[3] = 7'b0100011; legal_ops[4] = 7'b1100011; legal_ops[5] = 7'b1101111;
    legal_ops[6] = 7'b1100111; legal_ops[7] = 7'b0110111;
    reset = 1'b0; mem_ready = 1'b0; Opcode = 7'd0;

    // Reset held, then release into IDLE
    push(0, 1, 7'd0, 15'd0, 0);
    push(0, 1, 7'd0, 15'd0, 0);
    push(1, 1, 7'd0, 15'd0, 0);

    n0 = plan.size(); add_instr(7'b0110011, 0, 0, t); check_lit("len_R", plan.size() - n0, 4);
    n0 = plan.size(); add_instr(7'b0000011, 0, 3, t); check_lit("len_LW_wait3", plan.size() - n0, 8);
    n0 = plan.size(); add_instr(7'b0100011, 0, 0, t); check_lit("len_SW", plan.size() - n0, 4);
    n0 = plan.size(); add_instr(7'b1100011, 0, 0, t); check_lit("len_BR", plan.size() - n0, 3);
    n0 = plan.size(); add_instr(7'b0000011, 0, 0, t); check_lit("len_LW", plan.size() - n0, 5);
    n0 = plan.size(); add_instr(7'b1101111, 0, 0, t); check_lit("len_JAL", plan.size() - n0, 4);
    n0 = plan.size(); add_instr(7'b1111111, 0, 0, t); check_lit("len_illegal", plan.size() - n0, 24);
    check_lit("illegal_traps", int'(t), 1);
    n0 = plan.size(); add_instr(7'b0110011, MT, 0, t); check_lit("len_fetch_timeout", plan.size() - n0, 38);
    n0 = plan.size(); add_instr(7'b0010011, MT - 1, 0, t); check_lit("len_fetch_maxwait", plan.size() - n0, 19);
    check_lit("maxwait_no_trap", int'(t), 0);
    add_instr(7'b0100011, 0, MT, t);
    add_instr(7'b0110111, 0, 0, t);

    // Store aborted by reset while waiting in MEM
    push(1, 1, ro(), mk(1,1,0,2'b00,0,1,0,2'b00,0,0,0,2'b00), 0);
    push(1, 0, 7'b0100011, 15'd0, 0);
    push(1, 0, ro(), mk(0,0,1,2'b00,0,0,0,2'b00,0,0,0,2'b00), 0);
    push(1, 0, ro(), mk(0,0,0,2'b00,0,0,1,2'b00,0,0,0,2'b00), 0);
    push(1, 0, ro(), mk(0,0,0,2'b00,0,0,1,2'b00,0,0,0,2'b00), 0);
    push(0, 0, ro(), 15'd0, 0);
    push(1, 0, ro(), 15'd0, 0);
    add_instr(7'b1100111, 1, 0, t);
    add_instr(7'b0100011, 2, 1, t);

    // Randomised instruction mix with occasional timeouts and illegal opcodes
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 15);
      op = (r < 15) ? legal_ops[r % 8] : ro();
      r = $urandom_range(0, 19);
      wf = (r < 14) ? $urandom_range(0, 2) : (r < 18) ? MT - 1 : (r == 18) ? MT : 0;
      r = $urandom_range(0, 19);
      wm = (r < 14) ? $urandom_range(0, 3) : (r < 18) ? MT - 1 : (r == 18) ? MT : 0;
      add_instr(op, wf, wm, t);
    end

    play();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
